// File: rtl/uart_tx_slave.sv
// rtl/uart_tx_slave.sv - memory-mapped 8N1 UART transmitter with a 4-entry byte FIFO
module uart_tx_slave #(
    parameter int              DW      = 16,
    parameter int              AW      = 13,
    parameter int              FIFO_AW = 2,
    parameter logic [DW-1:0]   DIV_RST = 16'd434
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] din,
    input  logic [AW-1:0] addr,
    input  logic          we,
    output logic [DW-1:0] dout,
    output logic          tx,
    output logic          txe
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = FIFO_AW + 1;

    localparam logic [AW-1:0] A_TXDATA = AW'(0);
    localparam logic [AW-1:0] A_STATUS = AW'(1);
    localparam logic [AW-1:0] A_DIV    = AW'(2);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state, state_d;
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]      count, count_d;
    logic               ovf;
    logic [DW-1:0]      div, div_m1;
    logic [DW-1:0]      baud_cnt, baud_d;
    logic [2:0]         bit_idx, bit_d;
    logic [7:0]         shift, shift_d;
    logic               tx_d;
    logic               wr_txdata, wr_status, wr_div;
    logic               fifo_full, fifo_empty;
    logic               push, pop, ovf_set, bit_end;
    logic [DW-1:0]      rd_data;

    assign wr_txdata  = we && (addr == A_TXDATA);
    assign wr_status  = we && (addr == A_STATUS);
    assign wr_div     = we && (addr == A_DIV);

    // Fullness is judged before any same-cycle pop, so a write to a full FIFO always drops.
    assign fifo_full  = (count == CW'(DEPTH));
    assign fifo_empty = (count == '0);
    assign push       = wr_txdata && !fifo_full;
    assign ovf_set    = wr_txdata && fifo_full;

    assign div_m1     = div - DW'(1);
    assign bit_end    = (baud_cnt == '0);

    always_comb begin
        count_d = count;
        if (push && !pop) begin
            count_d = count + CW'(1);
        end else if (pop && !push) begin
            count_d = count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            div    <= DIV_RST;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            count <= count_d;
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (wr_status && din[3]) begin
                ovf <= 1'b0;
            end
            if (wr_div) begin
                div <= (din == '0) ? DW'(1) : din;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din[7:0];
        end
    end

    always_comb begin
        state_d = state;
        baud_d  = baud_cnt;
        bit_d   = bit_idx;
        shift_d = shift;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr];
                    baud_d  = div_m1;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_d  = div_m1;
                    bit_d   = 3'd0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_cnt - DW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d  = div_m1;
                    shift_d = {1'b0, shift[7:1]};
                    bit_d   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    baud_d = baud_cnt - DW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_d = div_m1;
                    // Chain straight into the next start bit when more data is waiting.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_cnt - DW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_comb begin
        rd_data = '0;
        case (addr)
            A_STATUS: rd_data = DW'({count, ovf, fifo_empty, fifo_full, (state != IDLE)});
            A_DIV:    rd_data = div;
            default:  rd_data = '0;
        endcase
    end

    // The line level is registered from the next-state decode so tx never glitches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
            txe      <= 1'b1;
            dout     <= '0;
        end else begin
            state    <= state_d;
            baud_cnt <= baud_d;
            bit_idx  <= bit_d;
            shift    <= shift_d;
            tx       <= tx_d;
            txe      <= (count_d == '0) && (state_d == IDLE);
            dout     <= rd_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_slave.sv
// tb/tb_uart_tx_slave.sv - directed self-checking bench for uart_tx_slave
module tb_uart_tx_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] din;
    logic [12:0] addr;
    logic        we;
    logic [15:0] dout;
    logic        tx;
    logic        txe;

    int check_cnt = 0;
    int pass_cnt  = 0;

    always #5 clk = ~clk;

    uart_tx_slave dut (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .addr (addr),
        .we   (we),
        .dout (dout),
        .tx   (tx),
        .txe  (txe)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    // Expected line level at sample pos of a frame (sample 0 = first start-bit cycle).
    function automatic logic exp_bit(input logic [7:0] b, input int div, input int pos);
        int slot;
        slot = pos / div;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
        return 1'b1;
    endfunction

    task automatic bus_write(input logic [12:0] a, input logic [15:0] d);
        @(negedge clk);
        addr = a;
        din  = d;
        we   = 1'b1;
        @(posedge clk);
        #1;
        we   = 1'b0;
        addr = '0;
        din  = '0;
    endtask

    task automatic bus_read(input logic [12:0] a, output logic [15:0] d);
        @(negedge clk);
        addr = a;
        we   = 1'b0;
        @(posedge clk);
        #1;
        d = dout;
    endtask

    task automatic wait_idle(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (txe) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        logic [15:0] d;
        check_cnt++;
        if (tx !== 1'b1) $display("FAIL por_tx: got %b required 1", tx); else pass_cnt++;
        check_cnt++;
        if (txe !== 1'b1) $display("FAIL por_txe: got %b required 1", txe); else pass_cnt++;
        check_cnt++;
        if (dout !== 16'h0000) $display("FAIL por_dout: got %h required 0000", dout); else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        bus_write(13'd0, 16'h0055);
        bus_read(13'd2, d);
        repeat (5) @(negedge clk);
        check_cnt++;
        if (tx !== 1'b0) $display("FAIL pre_reset_start_bit: got %b required 0", tx); else pass_cnt++;
        check_cnt++;
        if (dout !== 16'd434) $display("FAIL pre_reset_dout: got %0d required 434", dout); else pass_cnt++;
        #2;
        rst = 1'b0;
        #1;
        check_cnt++;
        if (tx !== 1'b1) $display("FAIL async_reset_tx: got %b required 1", tx); else pass_cnt++;
        check_cnt++;
        if (txe !== 1'b1) $display("FAIL async_reset_txe: got %b required 1", txe); else pass_cnt++;
        check_cnt++;
        if (dout !== 16'h0000) $display("FAIL async_reset_dout: got %h required 0000", dout); else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        bus_read(13'd1, d);
        check_cnt++;
        if (d !== 16'h0004) $display("FAIL reset_status: got %h required 0004", d); else pass_cnt++;
        bus_read(13'd2, d);
        check_cnt++;
        if (d !== 16'd434) $display("FAIL reset_div: got %0d required 434", d); else pass_cnt++;
        repeat (3) @(negedge clk);
        check_cnt++;
        if (tx !== 1'b1) $display("FAIL reset_fifo_discard_tx: got %b required 1", tx); else pass_cnt++;
    endtask

    task automatic test_single_frame;
        logic [15:0] d;
        int errs;
        int first;
        errs  = 0;
        first = -1;
        bus_write(13'd2, 16'd4);
        bus_write(13'd0, 16'h0055);
        @(negedge clk);
        check_cnt++;
        if (tx !== 1'b1) $display("FAIL single_prepop_tx: got %b required 1", tx); else pass_cnt++;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tx !== exp_bit(8'h55, 4, i)) begin
                errs++;
                if (first < 0) first = i;
            end
        end
        check_cnt++;
        if (errs != 0) $display("FAIL single_frame_wave: got %0d bad samples (first %0d) required 0", errs, first);
        else pass_cnt++;
        @(negedge clk);
        check_cnt++;
        if (tx !== 1'b1) $display("FAIL single_after_stop_tx: got %b required 1", tx); else pass_cnt++;
        repeat (2) @(negedge clk);
        check_cnt++;
        if (txe !== 1'b1) $display("FAIL single_txe: got %b required 1", txe); else pass_cnt++;
        bus_read(13'd1, d);
        check_cnt++;
        if (d !== 16'h0004) $display("FAIL single_status_idle: got %h required 0004", d); else pass_cnt++;
    endtask

    task automatic test_fifo_overflow;
        logic [15:0] d;
        logic [7:0]  b;
        int errs;
        int first;
        errs  = 0;
        first = -1;
        bus_write(13'd2, 16'd8);
        for (int n = 1; n <= 6; n++) bus_write(13'd0, 16'(n));
        bus_read(13'd1, d);
        check_cnt++;
        if (d !== 16'h004B) $display("FAIL ovf_status_full: got %h required 004b", d); else pass_cnt++;
        for (int i = 5; i < 400; i++) begin
            @(negedge clk);
            b = 8'(i / 80 + 1);
            if (tx !== exp_bit(b, 8, i % 80)) begin
                errs++;
                if (first < 0) first = i;
            end
        end
        check_cnt++;
        if (errs != 0) $display("FAIL ovf_five_frames_wave: got %0d bad samples (first %0d) required 0", errs, first);
        else pass_cnt++;
        @(negedge clk);
        check_cnt++;
        if (tx !== 1'b1) $display("FAIL ovf_idle_tx: got %b required 1", tx); else pass_cnt++;
        bus_read(13'd1, d);
        check_cnt++;
        if (d !== 16'h000C) $display("FAIL ovf_sticky: got %h required 000c", d); else pass_cnt++;
        bus_write(13'd1, 16'h0008);
        bus_read(13'd1, d);
        check_cnt++;
        if (d !== 16'h0004) $display("FAIL ovf_clear: got %h required 0004", d); else pass_cnt++;
    endtask

    task automatic test_push_pop_edge;
        logic [15:0] d;
        logic [7:0]  fb [4];
        int errs;
        int first;
        bit ok;
        errs  = 0;
        first = -1;
        fb[0] = 8'h33;
        fb[1] = 8'h44;
        fb[2] = 8'h55;
        fb[3] = 8'h77;
        bus_write(13'd2, 16'd4);
        bus_write(13'd0, 16'h0011);
        bus_write(13'd0, 16'h0022);
        bus_write(13'd0, 16'h0033);
        bus_write(13'd0, 16'h0044);
        bus_write(13'd0, 16'h0055);
        repeat (36) @(posedge clk);
        bus_write(13'd0, 16'h0066);
        bus_read(13'd1, d);
        check_cnt++;
        if (d !== 16'h0039) $display("FAIL edge_full_drop: got %h required 0039", d); else pass_cnt++;
        bus_write(13'd1, 16'h0008);
        repeat (37) @(posedge clk);
        bus_write(13'd0, 16'h0077);
        bus_read(13'd1, d);
        check_cnt++;
        if (d !== 16'h0031) $display("FAIL edge_count3_push: got %h required 0031", d); else pass_cnt++;
        for (int t = 1; t < 160; t++) begin
            @(negedge clk);
            if (tx !== exp_bit(fb[t / 40], 4, t % 40)) begin
                errs++;
                if (first < 0) first = t;
            end
        end
        check_cnt++;
        if (errs != 0) $display("FAIL edge_drain_wave: got %0d bad samples (first %0d) required 0", errs, first);
        else pass_cnt++;
        wait_idle(10, ok);
        check_cnt++;
        if (ok !== 1'b1) $display("FAIL edge_drain_idle: got txe %b required 1 within 10 cycles", txe); else pass_cnt++;
    endtask

    task automatic test_divisor;
        logic [15:0] d;
        logic        e;
        int errs;
        int first;
        errs  = 0;
        first = -1;
        bus_write(13'd2, 16'd0);
        bus_read(13'd2, d);
        check_cnt++;
        if (d !== 16'd1) $display("FAIL div_zero_readback: got %0d required 1", d); else pass_cnt++;
        bus_write(13'd0, 16'h00A3);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tx !== exp_bit(8'hA3, 1, i)) begin
                errs++;
                if (first < 0) first = i;
            end
        end
        check_cnt++;
        if (errs != 0) $display("FAIL div1_frame_wave: got %0d bad samples (first %0d) required 0", errs, first);
        else pass_cnt++;
        @(negedge clk);
        bus_read(13'd1, d);
        check_cnt++;
        if (d !== 16'h0004) $display("FAIL div1_frame_len: got %h required 0004", d); else pass_cnt++;

        errs  = 0;
        first = -1;
        bus_write(13'd2, 16'd4);
        bus_write(13'd0, 16'h00A3);
        @(negedge clk);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i < 20) e = exp_bit(8'hA3, 4, i);
            else if (i < 28) e = exp_bit(8'hA3, 2, 10 + (i - 20));
            else e = 1'b1;
            if (tx !== e) begin
                errs++;
                if (first < 0) first = i;
            end
            if (i == 16) begin
                addr = 13'd2;
                din  = 16'd2;
                we   = 1'b1;
            end else if (i == 17) begin
                we   = 1'b0;
                addr = '0;
                din  = '0;
            end
        end
        check_cnt++;
        if (errs != 0) $display("FAIL div_change_wave: got %0d bad samples (first %0d) required 0", errs, first);
        else pass_cnt++;
        @(negedge clk);
        bus_read(13'd1, d);
        check_cnt++;
        if (d !== 16'h0004) $display("FAIL div_change_stop_len: got %h required 0004", d); else pass_cnt++;
    endtask

    task automatic test_unmapped_and_latency;
        logic [15:0] d;
        bus_write(13'd5, 16'hFFFF);
        bus_write(13'd4, 16'h00AA);
        bus_write(13'd6, 16'h0003);
        repeat (2) @(negedge clk);
        check_cnt++;
        if (txe !== 1'b1) $display("FAIL unmapped_no_frame_txe: got %b required 1", txe); else pass_cnt++;
        bus_read(13'd1, d);
        check_cnt++;
        if (d !== 16'h0004) $display("FAIL unmapped_status: got %h required 0004", d); else pass_cnt++;
        bus_read(13'd2, d);
        check_cnt++;
        if (d !== 16'd2) $display("FAIL unmapped_div_kept: got %0d required 2", d); else pass_cnt++;
        bus_read(13'd5, d);
        check_cnt++;
        if (d !== 16'h0000) $display("FAIL unmapped_read: got %h required 0000", d); else pass_cnt++;
        @(negedge clk);
        addr = 13'd1;
        #1;
        check_cnt++;
        if (dout !== 16'h0000) $display("FAIL read_no_comb_path: got %h required 0000", dout); else pass_cnt++;
        @(negedge clk);
        addr = 13'd2;
        check_cnt++;
        if (dout !== 16'h0004) $display("FAIL b2b_read_status: got %h required 0004", dout); else pass_cnt++;
        @(negedge clk);
        addr = 13'd0;
        check_cnt++;
        if (dout !== 16'd2) $display("FAIL b2b_read_div: got %0d required 2", dout); else pass_cnt++;
        @(negedge clk);
        check_cnt++;
        if (dout !== 16'h0000) $display("FAIL b2b_read_txdata: got %h required 0000", dout); else pass_cnt++;
        check_cnt++;
        if (tx !== 1'b1) $display("FAIL unmapped_tx_idle: got %b required 1", tx); else pass_cnt++;
    endtask

    initial begin
        rst  = 1'b0;
        din  = '0;
        addr = '0;
        we   = 1'b0;
        repeat (3) @(negedge clk);
        test_reset;
        test_single_frame;
        test_fifo_overflow;
        test_push_pop_edge;
        test_divisor;
        test_unmapped_and_latency;
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
